fpu_issue: RTL and testbench

Core-side issue/writeback controller for the multi-cycle FPU. Accepts one FP operation at a time from decode with a valid/ready handshake, and drives the FPU's `fpuop`/`src0`/`src1` inputs, holding them stable until `fin`. It captures the result and emits a one-cycle writeback to either the FP or the integer register file. It sits between decode and the FPU, and is the initiator side of the FPU's op/fin protocol.

---
 rtl/fpu_issue.sv | 172 +++++++++++++++++
 tb/tb_fpu_issue.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue.sv
// fpu_issue: issue/writeback controller for the multi-cycle FPU.
// Accepts one FP op at a time from decode, holds opcode/operands on the FPU
// until fin, then produces a one-cycle writeback to the FP or integer file.
module fpu_issue #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rstn,
  // decode side
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [3:0]  req_op_i,
  input  logic [31:0] req_src0_i,
  input  logic [31:0] req_src1_i,
  input  logic [4:0]  req_rd_i,
  input  logic        flush_i,
  // FPU side
  output logic [3:0]  fpu_op_o,
  output logic [31:0] fpu_src0_o,
  output logic [31:0] fpu_src1_o,
  input  logic [31:0] fpu_result_i,
  input  logic        fpu_fin_i,
  // writeback
  output logic        wb_valid_o,
  output logic        wb_int_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  // status
  output logic        busy_o,
  output logic        err_timeout_o,
  output logic        err_illegal_o
);

  localparam int unsigned CntW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [3:0]  OpIdle = 4'b1111;

  typedef enum logic [0:0] {StIdle, StExec} state_e;

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [31:0]       src0_q, src0_d;
  logic [31:0]       src1_q, src1_d;
  logic [4:0]        rd_q, rd_d;
  logic              kill_q, kill_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_int_q, wb_int_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              err_to_q, err_to_d;
  logic              err_ill_q, err_ill_d;

  logic accept;
  logic op_illegal;
  logic op_is_int;

  // A new op may enter while idle, or on the fin cycle of the current op.
  assign req_ready_o = (state_q == StIdle) | ((state_q == StExec) & fpu_fin_i);
  assign accept      = req_valid_i & req_ready_o;

  // 1101..1111 are not real opcodes; 1000..1011 return integer results.
  assign op_illegal = (op_q >= 4'b1101);
  assign op_is_int  = (op_q[3:2] == 2'b10);

  // Next-state: issue, hold until fin, capture writeback, track errors.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    src0_d     = src0_q;
    src1_d     = src1_q;
    rd_d       = rd_q;
    kill_d     = kill_q;
    cnt_d      = cnt_q;
    wb_valid_d = 1'b0;
    wb_int_d   = wb_int_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    err_to_d   = err_to_q;
    err_ill_d  = err_ill_q;

    case (state_q)
      StIdle: begin
        // flush has no meaning without an op in flight
      end
      StExec: begin
        // The FPU cannot be aborted: a flush only suppresses the writeback.
        if (flush_i) begin
          kill_d = 1'b1;
        end
        if (fpu_fin_i) begin
          wb_data_d  = fpu_result_i;
          wb_rd_d    = rd_q;
          wb_int_d   = op_is_int;
          wb_valid_d = ~kill_q & ~flush_i & ~op_illegal;
          if (op_illegal) begin
            err_ill_d = 1'b1;
          end
          // Opcode must drop after fin or the FPU restarts the op.
          state_d = StIdle;
          op_d    = OpIdle;
        end else begin
          if (cnt_q != CntW'(TIMEOUT)) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (cnt_d == CntW'(TIMEOUT)) begin
            err_to_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        op_d    = OpIdle;
      end
    endcase

    // Accept overrides the fin-cycle return to idle (back-to-back issue).
    if (accept) begin
      state_d = StExec;
      op_d    = req_op_i;
      src0_d  = req_src0_i;
      src1_d  = req_src1_i;
      rd_d    = req_rd_i;
      kill_d  = 1'b0;
      cnt_d   = '0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StIdle;
      op_q       <= OpIdle;
      src0_q     <= '0;
      src1_q     <= '0;
      rd_q       <= '0;
      kill_q     <= 1'b0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_int_q   <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      err_to_q   <= 1'b0;
      err_ill_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      src0_q     <= src0_d;
      src1_q     <= src1_d;
      rd_q       <= rd_d;
      kill_q     <= kill_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_int_q   <= wb_int_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      err_to_q   <= err_to_d;
      err_ill_q  <= err_ill_d;
    end
  end

  assign fpu_op_o      = op_q;
  assign fpu_src0_o    = src0_q;
  assign fpu_src1_o    = src1_q;
  assign wb_valid_o    = wb_valid_q;
  assign wb_int_o      = wb_int_q;
  assign wb_rd_o       = wb_rd_q;
  assign wb_data_o     = wb_data_q;
  assign busy_o        = (state_q == StExec);
  assign err_timeout_o = err_to_q;
  assign err_illegal_o = err_ill_q;

endmodule

// File: tb/tb_fpu_issue.sv
// Bench for fpu_issue: FPU stub with per-opcode latency, a per-cycle
// reference model with a writeback scoreboard, directed and random stimulus.
module tb_fpu_issue;

  localparam int unsigned TO = 15;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [31:0] req_src0 = '0;
  logic [31:0] req_src1 = '0;
  logic [4:0]  req_rd = '0;
  logic        flush;
  logic        flush_dir = 1'b0;
  logic        flush_rnd = 1'b0;
  logic [3:0]  fpu_op;
  logic [31:0] fpu_src0, fpu_src1;
  logic [31:0] fpu_result = '0;
  logic        fpu_fin = 1'b0;
  logic        wb_valid, wb_int;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy, err_timeout, err_illegal;

  assign flush = flush_dir | flush_rnd;

  always #5 clk = ~clk;

  fpu_issue #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_op_i     (req_op),
    .req_src0_i   (req_src0),
    .req_src1_i   (req_src1),
    .req_rd_i     (req_rd),
    .flush_i      (flush),
    .fpu_op_o     (fpu_op),
    .fpu_src0_o   (fpu_src0),
    .fpu_src1_o   (fpu_src1),
    .fpu_result_i (fpu_result),
    .fpu_fin_i    (fpu_fin),
    .wb_valid_o   (wb_valid),
    .wb_int_o     (wb_int),
    .wb_rd_o      (wb_rd),
    .wb_data_o    (wb_data),
    .busy_o       (busy),
    .err_timeout_o(err_timeout),
    .err_illegal_o(err_illegal)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // FPU latency in cycles after the opcode appears.
  function automatic int lat(input logic [3:0] op);
    case (op)
      4'd0, 4'd1:   return 3;
      4'd2:         return 2;
      4'd3:         return 10;
      4'd4:         return 7;
      4'd11, 4'd12: return 1;
      default:      return 0;
    endcase
  endfunction

  // Stand-in FPU arithmetic; only needs to be deterministic per operand set.
  function automatic logic [31:0] fmodel(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    if (op == 4'd0 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    case (op)
      4'd8:    return {31'd0, a == b};
      4'd9:    return {31'd0, a <= b};
      4'd10:   return {31'd0, a < b};
      default: return (a + b) ^ {28'd0, op};
    endcase
  endfunction

  // FPU stub: fin L cycles after the opcode is first presented.
  logic       stub_dead = 1'b0;
  logic       st_on = 1'b0;
  logic [3:0] st_rem = '0;
  always @(posedge clk) begin
    if (!rstn) begin
      st_on   <= 1'b0;
      st_rem  <= '0;
      fpu_fin <= 1'b0;
    end else if (req_valid && req_ready) begin
      st_on      <= 1'b1;
      st_rem     <= 4'(lat(req_op));
      fpu_fin    <= (lat(req_op) == 0) && !stub_dead;
      fpu_result <= fmodel(req_op, req_src0, req_src1);
    end else if (st_on && !fpu_fin) begin
      st_rem  <= st_rem - 4'd1;
      fpu_fin <= (st_rem == 4'd1) && !stub_dead;
    end else if (fpu_fin) begin
      fpu_fin <= 1'b0;
      st_on   <= 1'b0;
    end
  end

  // Reference model state and writeback scoreboard.
  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic        is_int;
    logic [31:0] data;
  } wb_t;
  wb_t exp_q[$];

  bit          m_inf = 0, m_kill = 0, m_eto = 0, m_eill = 0;
  int          m_cnt = 0;
  logic [3:0]  m_op = 4'hF;
  logic [31:0] m_s0 = '0, m_s1 = '0, m_wdata = '0;
  logic [4:0]  m_rd = '0, m_wrd = '0;
  logic        m_wint = 1'b0;

  // Monitor: compare every output each cycle, then advance the model.
  always @(negedge clk) begin
    bit ready_m, want_wb;
    wb_t e;
    if (!rstn) begin
      m_inf = 0; m_kill = 0; m_eto = 0; m_eill = 0; m_cnt = 0;
      m_s0 = '0; m_s1 = '0; m_wdata = '0; m_wrd = '0; m_wint = 1'b0;
      exp_q.delete();
    end else begin
      ready_m = !m_inf || fpu_fin;
      chk("req_ready", {31'd0, req_ready}, {31'd0, ready_m});
      chk("busy", {31'd0, busy}, {31'd0, m_inf});
      chk("fpu_op", {28'd0, fpu_op}, {28'd0, m_inf ? m_op : 4'hF});
      chk("fpu_src0", fpu_src0, m_s0);
      chk("fpu_src1", fpu_src1, m_s1);
      chk("err_timeout", {31'd0, err_timeout}, {31'd0, m_eto});
      chk("err_illegal", {31'd0, err_illegal}, {31'd0, m_eill});
      want_wb = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk("wb_valid", {31'd0, wb_valid}, {31'd0, want_wb});
      if (want_wb) begin
        e = exp_q.pop_front();
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
        chk("wb_int", {31'd0, wb_int}, {31'd0, e.is_int});
        chk("wb_data", wb_data, e.data);
      end else begin
        chk("wb_rd_hold", {27'd0, wb_rd}, {27'd0, m_wrd});
        chk("wb_int_hold", {31'd0, wb_int}, {31'd0, m_wint});
        chk("wb_data_hold", wb_data, m_wdata);
      end

      if (m_inf) begin
        if (flush) m_kill = 1;
        if (fpu_fin) begin
          m_wrd   = m_rd;
          m_wint  = (m_op >= 4'd8 && m_op <= 4'd11);
          m_wdata = fmodel(m_op, m_s0, m_s1);
          if (m_op >= 4'd13) m_eill = 1;
          else if (!m_kill) exp_q.push_back('{cyc + 1, m_wrd, m_wint, m_wdata});
          m_inf = 0;
        end else begin
          m_cnt++;
          if (m_cnt == int'(TO)) m_eto = 1;
        end
      end
      if (req_valid && ready_m) begin
        m_inf = 1; m_kill = 0; m_cnt = 0;
        m_op = req_op; m_s0 = req_src0; m_s1 = req_src1; m_rd = req_rd;
      end
    end
  end

  // Present a request from just after a posedge; returns 1 time unit after
  // the edge that follows acceptance.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    bit got = 0;
    req_valid = 1'b1; req_op = op; req_src0 = a; req_src1 = b; req_rd = rd;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (req_ready) got = 1;
      else begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL issue_accept op=%h: got no accept want accept within 64 cycles", op);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic rand_en = 1'b0;
  initial begin
    forever begin
      @(posedge clk); #1;
      flush_rnd = rand_en && ($urandom_range(0, 11) == 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1);
  end

  initial begin
    step(3);
    rstn = 1'b1;
    step(1);

    // fadd 1.0 + 2.0
    issue(4'd0, 32'h3F800000, 32'h40000000, 5'd3);
    repeat (5) @(negedge clk);
    chk("fadd_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("fadd_wb_int", {31'd0, wb_int}, 32'd0);
    chk("fadd_wb_data", wb_data, 32'h40400000);
    step(1);

    // feq with equal operands
    issue(4'd8, 32'h40490FDB, 32'h40490FDB, 5'd7);
    repeat (2) @(negedge clk);
    chk("feq_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("feq_wb_int", {31'd0, wb_int}, 32'd1);
    chk("feq_wb_rd", {27'd0, wb_rd}, 32'd7);
    chk("feq_wb_data", wb_data, 32'd1);
    chk("feq_fpu_op_idle", {28'd0, fpu_op}, 32'hF);
    step(1);

    // fmul then fdiv back-to-back
    issue(4'd2, 32'h11111111, 32'h22222222, 5'd4);
    issue(4'd3, 32'h33333333, 32'h44444444, 5'd9);
    repeat (12) @(negedge clk);
    chk("b2b_fdiv_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("b2b_fdiv_wb_rd", {27'd0, wb_rd}, 32'd9);
    step(1);

    // fsqrt flushed mid-flight
    issue(4'd4, 32'h40800000, 32'h0, 5'd12);
    step(2);
    flush_dir = 1'b1;
    step(1);
    flush_dir = 1'b0;
    repeat (5) @(negedge clk);
    chk("flush_ready_at_fin", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    chk("flush_no_wb", {31'd0, wb_valid}, 32'd0);
    chk("flush_fpu_op_idle", {28'd0, fpu_op}, 32'hF);
    step(1);

    // illegal opcode
    issue(4'd14, 32'h5, 32'h6, 5'd1);
    repeat (3) @(negedge clk);
    chk("illegal_flag", {31'd0, err_illegal}, 32'd1);
    step(1);

    // reset in the middle of an fdiv
    issue(4'd3, 32'h1, 32'h2, 5'd20);
    step(4);
    rstn = 1'b0;
    step(1);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_fpu_op", {28'd0, fpu_op}, 32'hF);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_err_illegal", {31'd0, err_illegal}, 32'd0);
    step(15);

    // timeout with the FPU never finishing
    stub_dead = 1'b1;
    issue(4'd0, 32'h7, 32'h8, 5'd2);
    repeat (15) @(negedge clk);
    chk("timeout_not_yet", {31'd0, err_timeout}, 32'd0);
    @(negedge clk);
    chk("timeout_flag", {31'd0, err_timeout}, 32'd1);
    step(4);
    rstn = 1'b0;
    stub_dead = 1'b0;
    step(1);
    rstn = 1'b1;
    step(1);

    // random traffic with random flushes and back-to-back issue
    rand_en = 1'b1;
    for (int n = 0; n < 300; n++) begin
      step($urandom_range(0, 2));
      issue(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom,
            5'($urandom_range(0, 31)));
    end
    rand_en = 1'b0;
    step(20);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
